pipe_hazard_ctrl: RTL and testbench



---
 rtl/pipe_hazard_ctrl_if.sv | 36 +++
 rtl/pipe_hazard_ctrl.sv | 101 ++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage request and pipeline-control response bundle for pipe_hazard_ctrl.
// FW must equal $clog2(DEPTH+1) of the attached controller.
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = 3,
    parameter int FW     = 2,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_rs_en;
    logic              id_rt_en;
    logic [REG_AW-1:0] id_rd;
    logic              id_reg_wr;
    logic              id_mem_rd;
    logic              br_taken;
    logic              pc_wr;
    logic              if_id_wr;
    logic              if_id_flush;
    logic              id_ex_bubble;
    logic [FW-1:0]     fwd_a;
    logic [FW-1:0]     fwd_b;
    logic              ex_valid;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_rs_en, id_rt_en, id_rd, id_reg_wr, id_mem_rd, br_taken,
        input  pc_wr, if_id_wr, if_id_flush, id_ex_bubble, fwd_a, fwd_b, ex_valid, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rs_en, id_rt_en, id_rd, id_reg_wr, id_mem_rd, br_taken,
        output pc_wr, if_id_wr, if_id_flush, id_ex_bubble, fwd_a, fwd_b, ex_valid, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard detection, forwarding select and PC/IF/ID/ID-EX control for an in-order pipe.
// A shadow record of each back-end stage drives all decisions combinationally.
module pipe_hazard_ctrl #(
    parameter int DEPTH    = 3,
    parameter int REG_AW   = 3,
    parameter int LOAD_LAT = 1,
    parameter int ZERO_REG = 1,
    parameter int CNT_W    = 16,
    localparam int FW      = $clog2(DEPTH+1)
) (
    input  logic             clk,
    input  logic             rst,
    pipe_hazard_ctrl_if.slave bus
);
    logic [DEPTH:1]             r_vld_pipe;
    logic [DEPTH:1]             r_wr;
    logic [DEPTH:1]             r_ld;
    logic [DEPTH:1][REG_AW-1:0] r_rd;
    logic [REG_AW-1:0]          r_rs;
    logic [REG_AW-1:0]          r_rt;
    logic                       r_rs_en;
    logic                       r_rt_en;
    logic [CNT_W-1:0]           r_stall_cnt;
    logic [CNT_W-1:0]           r_flush_cnt;

    logic          w_lu;
    logic          w_flush;
    logic          w_stall;
    logic          w_bubble;
    logic [FW-1:0] w_fwd_a;
    logic [FW-1:0] w_fwd_b;

    function automatic logic f_match(input logic [REG_AW-1:0] src, input logic en,
                                     input logic vld, input logic wr, input logic [REG_AW-1:0] rd);
        return vld && wr && en && (rd == src) && !(ZERO_REG != 0 && src == '0);
    endfunction

    always_comb begin
        w_lu = 1'b0;
        for (int j = 1; j <= LOAD_LAT; j++) begin
            if (r_ld[j] && (f_match(bus.id_rs, bus.id_rs_en, r_vld_pipe[j], r_wr[j], r_rd[j]) ||
                            f_match(bus.id_rt, bus.id_rt_en, r_vld_pipe[j], r_wr[j], r_rd[j])))
                w_lu = 1'b1;
        end
        w_lu = w_lu && bus.id_valid;

        // Walk oldest to youngest so the youngest eligible writer lands last.
        w_fwd_a = '0;
        w_fwd_b = '0;
        for (int k = DEPTH; k >= 2; k--) begin
            if (!r_ld[k] || k >= LOAD_LAT + 2) begin
                if (f_match(r_rs, r_rs_en, r_vld_pipe[k], r_wr[k], r_rd[k]))
                    w_fwd_a = FW'(k);
                if (f_match(r_rt, r_rt_en, r_vld_pipe[k], r_wr[k], r_rd[k]))
                    w_fwd_b = FW'(k);
            end
        end
    end

    assign w_flush  = bus.br_taken && r_vld_pipe[1];
    assign w_stall  = w_lu && !w_flush;
    assign w_bubble = w_stall || w_flush;

    assign bus.pc_wr        = !w_stall;
    assign bus.if_id_wr     = !w_stall;
    assign bus.if_id_flush  = w_flush;
    assign bus.id_ex_bubble = w_bubble;
    assign bus.fwd_a        = w_fwd_a;
    assign bus.fwd_b        = w_fwd_b;
    assign bus.ex_valid     = r_vld_pipe[1];
    assign bus.stall_cnt    = r_stall_cnt;
    assign bus.flush_cnt    = r_flush_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_pipe  <= '0;
            r_wr        <= '0;
            r_ld        <= '0;
            r_rd        <= '0;
            r_rs        <= '0;
            r_rt        <= '0;
            r_rs_en     <= 1'b0;
            r_rt_en     <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[DEPTH-1:1], bus.id_valid && !w_bubble};
            r_wr       <= {r_wr[DEPTH-1:1], bus.id_reg_wr};
            r_ld       <= {r_ld[DEPTH-1:1], bus.id_mem_rd};
            r_rd       <= {r_rd[DEPTH-1:1], bus.id_rd};
            r_rs       <= bus.id_rs;
            r_rt       <= bus.id_rt;
            r_rs_en    <= bus.id_rs_en;
            r_rt_en    <= bus.id_rt_en;
            if (w_stall && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_flush && r_flush_cnt != '1)
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: default controller (dut_a) and a deep, ZERO_REG=0, 2-bit-counter one (dut_g)
// share one ID stimulus stream; each section checks the instance it targets.
module tb_pipe_hazard_ctrl;
    logic clk;
    logic rst;
    logic       s_valid, s_rs_en, s_rt_en, s_wr, s_ld, s_br;
    logic [2:0] s_rs, s_rt, s_rd;
    int n_vec;
    int n_err;

    pipe_hazard_ctrl_if #(.REG_AW(3), .FW(2), .CNT_W(16)) ifa ();
    pipe_hazard_ctrl_if #(.REG_AW(3), .FW(3), .CNT_W(2))  ifg ();

    pipe_hazard_ctrl #(.DEPTH(3), .REG_AW(3), .LOAD_LAT(1), .ZERO_REG(1), .CNT_W(16))
        dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    pipe_hazard_ctrl #(.DEPTH(5), .REG_AW(3), .LOAD_LAT(2), .ZERO_REG(0), .CNT_W(2))
        dut_g (.clk(clk), .rst(rst), .bus(ifg.slave));

    assign ifa.id_valid = s_valid;  assign ifg.id_valid = s_valid;
    assign ifa.id_rs    = s_rs;     assign ifg.id_rs    = s_rs;
    assign ifa.id_rt    = s_rt;     assign ifg.id_rt    = s_rt;
    assign ifa.id_rs_en = s_rs_en;  assign ifg.id_rs_en = s_rs_en;
    assign ifa.id_rt_en = s_rt_en;  assign ifg.id_rt_en = s_rt_en;
    assign ifa.id_rd    = s_rd;     assign ifg.id_rd    = s_rd;
    assign ifa.id_reg_wr = s_wr;    assign ifg.id_reg_wr = s_wr;
    assign ifa.id_mem_rd = s_ld;    assign ifg.id_mem_rd = s_ld;
    assign ifa.br_taken = s_br;     assign ifg.br_taken = s_br;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [2:0] rs, input logic rse, input logic [2:0] rt,
                       input logic rte, input logic [2:0] rd, input logic wr, input logic ld);
        s_valid = v;  s_rs = rs;  s_rs_en = rse;  s_rt = rt;  s_rt_en = rte;
        s_rd = rd;    s_wr = wr;  s_ld = ld;
        #1;
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        s_br = 1'b0;
        idle();
        #1;
        chk("rst_pc_wr", ifa.pc_wr, 1);
        chk("rst_if_id_wr", ifa.if_id_wr, 1);
        chk("rst_flush", ifa.if_id_flush, 0);
        chk("rst_bubble", ifa.id_ex_bubble, 0);
        chk("rst_fwd_a", ifa.fwd_a, 0);
        chk("rst_fwd_b", ifa.fwd_b, 0);
        chk("rst_ex_valid", ifa.ex_valid, 0);
        chk("rst_stall_cnt", ifa.stall_cnt, 0);
        chk("rst_flush_cnt", ifa.flush_cnt, 0);
        tick();
        rst = 1'b0;

        // ALU chain: back-to-back, then with one independent instruction between
        drv(1, 2, 1, 3, 1, 1, 1, 0);
        chk("alu_nostall0", ifa.pc_wr, 1);
        tick(); drv(1, 1, 1, 5, 1, 6, 1, 0);
        chk("alu_nostall1", ifa.pc_wr, 1);
        chk("alu_ex_valid", ifa.ex_valid, 1);
        tick(); idle();
        chk("alu_fwd_a2", ifa.fwd_a, 2);
        chk("alu_fwd_b0", ifa.fwd_b, 0);
        tick(); drv(1, 2, 1, 3, 1, 1, 1, 0);
        tick(); drv(1, 2, 1, 3, 1, 7, 1, 0);
        tick(); drv(1, 1, 1, 5, 0, 6, 1, 0);
        tick(); idle();
        chk("alu_fwd_a3", ifa.fwd_a, 3);

        // Load-use via rt
        tick(); drv(1, 2, 1, 0, 0, 3, 1, 1);
        tick(); drv(1, 4, 1, 3, 1, 5, 1, 0);
        chk("lu_pc_wr", ifa.pc_wr, 0);
        chk("lu_if_id_wr", ifa.if_id_wr, 0);
        chk("lu_bubble", ifa.id_ex_bubble, 1);
        chk("lu_no_flush", ifa.if_id_flush, 0);
        chk("lu_cnt_before", ifa.stall_cnt, 0);
        tick();
        chk("lu_cnt_after", ifa.stall_cnt, 1);
        chk("lu_release_pc_wr", ifa.pc_wr, 1);
        chk("lu_release_bubble", ifa.id_ex_bubble, 0);
        tick(); idle();
        chk("lu_fwd_b3", ifa.fwd_b, 3);
        chk("lu_fwd_a0", ifa.fwd_a, 0);
        chk("lu_ex_valid", ifa.ex_valid, 1);
        tick(); drv(1, 2, 1, 0, 0, 3, 1, 1);
        tick(); drv(1, 4, 1, 3, 0, 5, 1, 0);
        chk("lu_rt_dis_pc_wr", ifa.pc_wr, 1);
        chk("lu_rt_dis_cnt", ifa.stall_cnt, 1);

        // Two writers of r4: youngest wins
        tick(); drv(1, 2, 1, 3, 1, 4, 1, 0);
        tick(); drv(1, 2, 1, 3, 1, 4, 1, 0);
        tick(); drv(1, 4, 1, 3, 0, 5, 1, 0);
        tick(); idle();
        chk("prio_fwd_a2", ifa.fwd_a, 2);

        // Register 0: exempt in dut_a, a real hazard in dut_g
        tick(); drv(1, 2, 1, 3, 0, 0, 1, 1);
        tick(); drv(1, 0, 1, 0, 1, 5, 1, 0);
        chk("zero_a_nostall", ifa.pc_wr, 1);
        chk("zero_g_stall", ifg.pc_wr, 0);
        tick(); idle();
        tick(); drv(1, 2, 1, 3, 0, 0, 1, 0);
        tick(); drv(1, 0, 1, 3, 0, 5, 1, 0);
        tick(); idle();
        chk("zero_a_fwd0", ifa.fwd_a, 0);
        chk("zero_g_fwd2", ifg.fwd_a, 2);

        // Flush overrides a pending load-use stall
        tick(); drv(1, 2, 1, 0, 0, 3, 1, 1);
        tick(); s_br = 1'b1; drv(1, 4, 0, 3, 1, 5, 1, 0);
        chk("fl_flush", ifa.if_id_flush, 1);
        chk("fl_bubble", ifa.id_ex_bubble, 1);
        chk("fl_pc_wr", ifa.pc_wr, 1);
        chk("fl_if_id_wr", ifa.if_id_wr, 1);
        tick(); idle();
        chk("fl_ex_valid0", ifa.ex_valid, 0);
        chk("fl_ignored", ifa.if_id_flush, 0);
        chk("fl_ignored_pc", ifa.pc_wr, 1);
        chk("fl_cnt", ifa.flush_cnt, 1);
        chk("fl_stall_cnt", ifa.stall_cnt, 1);
        tick(); s_br = 1'b0; idle();
        chk("fl_cnt_hold", ifa.flush_cnt, 1);

        // Deep pipe, LOAD_LAT=2: two stall cycles then forward from stage 4
        rst = 1'b1; #1; rst = 1'b0;
        tick(); drv(1, 2, 0, 0, 0, 3, 1, 1);
        tick(); drv(1, 3, 1, 0, 0, 5, 1, 0);
        chk("gen_stall1", ifg.pc_wr, 0);
        tick();
        chk("gen_stall2", ifg.pc_wr, 0);
        tick();
        chk("gen_release", ifg.pc_wr, 1);
        chk("gen_cnt2", ifg.stall_cnt, 2);
        tick(); idle();
        chk("gen_fwd4", ifg.fwd_a, 4);
        for (int r = 0; r < 2; r++) begin
            tick(); drv(1, 2, 0, 0, 0, 3, 1, 1);
            tick(); drv(1, 3, 1, 0, 0, 5, 1, 0);
            tick(); tick(); idle();
            chk("gen_cnt_sat", ifg.stall_cnt, 3);
        end

        // Reset during a stall cycle
        rst = 1'b1; #1; rst = 1'b0;
        tick(); drv(1, 2, 1, 0, 0, 3, 1, 1);
        tick(); drv(1, 4, 0, 3, 1, 5, 1, 0);
        tick();
        tick(); drv(1, 2, 1, 0, 0, 3, 1, 1);
        tick(); drv(1, 4, 0, 3, 1, 5, 1, 0);
        chk("rms_stall", ifa.pc_wr, 0);
        chk("rms_cnt_pre", ifa.stall_cnt, 1);
        rst = 1'b1; #1;
        chk("rms_pc_wr", ifa.pc_wr, 1);
        chk("rms_bubble", ifa.id_ex_bubble, 0);
        chk("rms_stall_cnt", ifa.stall_cnt, 0);
        chk("rms_ex_valid", ifa.ex_valid, 0);
        tick(); rst = 1'b0; #1;
        chk("rms_post_pc_wr", ifa.pc_wr, 1);
        tick(); idle();
        chk("rms_post_ex_valid", ifa.ex_valid, 1);
        chk("rms_post_fwd_b", ifa.fwd_b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
